// File: rtl/reg_window_pkg.sv
// rtl/reg_window_pkg.sv - op encodings, FSM states and default sizes for the register window controller
package reg_window_pkg;

    localparam int DEF_NWINDOWS = 4;
    localparam int DEF_CWP_W    = 2;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SAVE       = 3'd1,
        OP_RESTORE    = 3'd2,
        OP_TRAP_ENTER = 3'd3,
        OP_RETT       = 3'd4,
        OP_WR_CWP     = 3'd5,
        OP_WR_WIM     = 3'd6,
        OP_RSVD       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_TRAP = 2'd2
    } state_e;

endpackage

// File: rtl/reg_window_ctrl_if.sv
// rtl/reg_window_ctrl_if.sv - control-unit side request/response bundle of the window controller
interface reg_window_ctrl_if #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 2
);
    logic                req;
    logic [2:0]          op;
    logic [31:0]         data_in;
    logic                trap_ack;
    logic                done;
    logic                illegal;
    logic                busy;
    logic                trap_ovf;
    logic                trap_unf;
    logic [CWP_W-1:0]    cwp;
    logic [NWINDOWS-1:0] wim;
    logic [NWINDOWS-1:0] current_window;

    modport master (
        output req, op, data_in, trap_ack,
        input  done, illegal, busy, trap_ovf, trap_unf, cwp, wim, current_window
    );

    modport slave (
        input  req, op, data_in, trap_ack,
        output done, illegal, busy, trap_ovf, trap_unf, cwp, wim, current_window
    );
endinterface

// File: rtl/window_mod_step.sv
// rtl/window_mod_step.sv - next-CWP candidate (inc/dec modulo NWINDOWS or direct load) and its one-hot decode
module window_mod_step #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 2
) (
    input  logic [CWP_W-1:0]    i_cwp,
    input  logic                i_dec,
    input  logic                i_load,
    input  logic [CWP_W-1:0]    i_load_val,
    output logic [CWP_W-1:0]    o_next,
    output logic [NWINDOWS-1:0] o_onehot
);
    localparam logic [CWP_W-1:0] LAST = CWP_W'(NWINDOWS - 1);

    logic [CWP_W-1:0] w_inc;
    logic [CWP_W-1:0] w_dec;

    // Explicit wrap so non-power-of-two window counts stay in range
    assign w_inc = (i_cwp == LAST) ? '0 : i_cwp + CWP_W'(1);
    assign w_dec = (i_cwp == '0) ? LAST : i_cwp - CWP_W'(1);

    always_comb begin
        o_next = w_inc;
        if (i_load) begin
            o_next = i_load_val;
        end else if (i_dec) begin
            o_next = w_dec;
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NWINDOWS; i++) begin
            o_onehot[i] = (o_next == CWP_W'(i));
        end
    end
endmodule

// File: rtl/reg_window_ctrl.sv
// rtl/reg_window_ctrl.sv - CWP/WIM sequencer with overflow/underflow traps; WINCTL_TRAPCNT_EN adds trap counters
module reg_window_ctrl
    import reg_window_pkg::*;
#(
    parameter int                  NWINDOWS = DEF_NWINDOWS,
    parameter int                  CWP_W    = DEF_CWP_W,
    parameter logic [NWINDOWS-1:0] WIM_RST  = '0
) (
    input  logic Clk,
    input  logic Clr,
    reg_window_ctrl_if.slave bus
`ifdef WINCTL_TRAPCNT_EN
    ,
    output logic [15:0] ovf_count,
    output logic [15:0] unf_count
`endif
);
    localparam logic [CWP_W:0] NW_EXT = (CWP_W + 1)'(NWINDOWS);

    state_e              r_state;
    op_e                 r_op;
    logic [NWINDOWS-1:0] r_data;
    logic [CWP_W-1:0]    r_cwp;
    logic [NWINDOWS-1:0] r_wim;
    logic [NWINDOWS-1:0] r_cw;
    logic                r_done;
    logic                r_illegal;
    logic                r_busy;
    logic                r_ovf;
    logic                r_unf;

    logic [CWP_W-1:0]    w_next;
    logic [NWINDOWS-1:0] w_onehot;
    logic                w_blocked;
    logic                w_cwp_bad;
    logic                w_enter_ovf;
    logic                w_enter_unf;
    logic                w_unused;

    window_mod_step #(
        .NWINDOWS (NWINDOWS),
        .CWP_W    (CWP_W)
    ) u_step (
        .i_cwp      (r_cwp),
        .i_dec      ((r_op == OP_SAVE) || (r_op == OP_TRAP_ENTER)),
        .i_load     (r_op == OP_WR_CWP),
        .i_load_val (r_data[CWP_W-1:0]),
        .o_next     (w_next),
        .o_onehot   (w_onehot)
    );

    assign w_blocked   = |(r_wim & w_onehot);
    assign w_cwp_bad   = {1'b0, r_data[CWP_W-1:0]} >= NW_EXT;
    assign w_enter_ovf = (r_state == S_EXEC) && (r_op == OP_SAVE) && w_blocked;
    assign w_enter_unf = (r_state == S_EXEC) && ((r_op == OP_RESTORE) || (r_op == OP_RETT)) && w_blocked;
    assign w_unused    = ^bus.data_in;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NOP;
            r_data    <= '0;
            r_cwp     <= '0;
            r_wim     <= WIM_RST;
            r_cw      <= NWINDOWS'(1);
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_op    <= op_e'(bus.op);
                        r_data  <= bus.data_in[NWINDOWS-1:0];
                        r_state <= S_EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (w_enter_ovf || w_enter_unf) begin
                        r_ovf   <= w_enter_ovf;
                        r_unf   <= w_enter_unf;
                        r_state <= S_TRAP;
                        r_busy  <= 1'b1;
                    end else begin
                        case (r_op)
                            OP_SAVE, OP_RESTORE, OP_RETT, OP_TRAP_ENTER: begin
                                r_cwp <= w_next;
                                r_cw  <= w_onehot;
                            end
                            OP_WR_CWP: begin
                                if (w_cwp_bad) begin
                                    r_illegal <= 1'b1;
                                end else begin
                                    r_cwp <= w_next;
                                    r_cw  <= w_onehot;
                                end
                            end
                            OP_WR_WIM: r_wim     <= r_data;
                            OP_RSVD:   r_illegal <= 1'b1;
                            default:   ;
                        endcase
                    end
                end
                S_TRAP: begin
                    // r_done is still high in the cycle the trap was raised; ack only counts after it
                    if (bus.trap_ack && !r_done) begin
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WINCTL_TRAPCNT_EN
    always_ff @(posedge Clk) begin
        if (Clr) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            if (w_enter_ovf && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
            if (w_enter_unf && (unf_count != 16'hFFFF)) begin
                unf_count <= unf_count + 16'd1;
            end
        end
    end
`endif

    assign bus.done           = r_done;
    assign bus.illegal        = r_illegal;
    assign bus.busy           = r_busy;
    assign bus.trap_ovf       = r_ovf;
    assign bus.trap_unf       = r_unf;
    assign bus.cwp            = r_cwp;
    assign bus.wim            = r_wim;
    assign bus.current_window = r_cw;
endmodule

// File: tb/tb_reg_window_ctrl.sv
// tb/tb_reg_window_ctrl.sv - directed bench for reg_window_ctrl (4-window and 3-window instances)
module tb_reg_window_ctrl;
    logic clk;
    logic Clr;
    int   n_checks;
    int   n_fail;

    reg_window_ctrl_if #(.NWINDOWS(4), .CWP_W(2)) bus ();
    reg_window_ctrl_if #(.NWINDOWS(3), .CWP_W(2)) bus3 ();

`ifdef WINCTL_TRAPCNT_EN
    logic [15:0] ovf_count, unf_count, ovf_count3, unf_count3;
`endif

    reg_window_ctrl #(.NWINDOWS(4), .CWP_W(2), .WIM_RST(4'b0000)) dut (
        .Clk (clk),
        .Clr (Clr),
        .bus (bus)
`ifdef WINCTL_TRAPCNT_EN
        ,
        .ovf_count (ovf_count),
        .unf_count (unf_count)
`endif
    );

    reg_window_ctrl #(.NWINDOWS(3), .CWP_W(2), .WIM_RST(3'b000)) dut3 (
        .Clk (clk),
        .Clr (Clr),
        .bus (bus3)
`ifdef WINCTL_TRAPCNT_EN
        ,
        .ovf_count (ovf_count3),
        .unf_count (unf_count3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns just after the negedge of the cycle in which done is expected
    task automatic issue(input logic [2:0] o, input logic [31:0] d);
        @(negedge clk);
        bus.req = 1'b1; bus.op = o; bus.data_in = d;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue3(input logic [2:0] o, input logic [31:0] d);
        @(negedge clk);
        bus3.req = 1'b1; bus3.op = o; bus3.data_in = d;
        @(negedge clk);
        bus3.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        Clr = 1'b1;
        repeat (2) @(negedge clk);
        Clr = 1'b0;
        n_checks++;
        if (bus.cwp !== 2'd0) begin n_fail++; $display("FAIL reset_cwp: got %0d expected 0", bus.cwp); end
        n_checks++;
        if (bus.wim !== 4'h0) begin n_fail++; $display("FAIL reset_wim: got %h expected 0", bus.wim); end
        n_checks++;
        if (bus.current_window !== 4'b0001) begin n_fail++; $display("FAIL reset_cw: got %b expected 0001", bus.current_window); end
        n_checks++;
        if ({bus.done, bus.illegal, bus.busy, bus.trap_ovf, bus.trap_unf} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus.done, bus.illegal, bus.busy, bus.trap_ovf, bus.trap_unf});
        end
    endtask

    task automatic test_save;
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'd1; bus.data_in = '0;
        @(negedge clk);
        bus.req = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin n_fail++; $display("FAIL save_exec_phase: busy,done got %b expected 10", {bus.busy, bus.done}); end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.illegal !== 1'b0) begin n_fail++; $display("FAIL save_done: done,illegal got %b%b expected 10", bus.done, bus.illegal); end
        n_checks++;
        if (bus.cwp !== 2'd3 || bus.current_window !== 4'b1000) begin
            n_fail++; $display("FAIL save_wrap: cwp %0d cw %b expected 3 1000", bus.cwp, bus.current_window);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL save_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_overflow;
        issue(3'd6, 32'h4);
        n_checks++;
        if (bus.wim !== 4'h4) begin n_fail++; $display("FAIL ovf_wim: got %h expected 4", bus.wim); end
        issue(3'd1, 32'h0);
        n_checks++;
        if ({bus.done, bus.trap_ovf, bus.busy} !== 3'b111 || bus.cwp !== 2'd3) begin
            n_fail++; $display("FAIL ovf_raise: done,ovf,busy %b cwp %0d expected 111 3", {bus.done, bus.trap_ovf, bus.busy}, bus.cwp);
        end
        bus.trap_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.trap_ovf !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL ovf_ack_same_cycle: ovf %b done %b expected 1 0", bus.trap_ovf, bus.done);
        end
        @(negedge clk);
        bus.trap_ack = 1'b0;
        n_checks++;
        if (bus.trap_ovf !== 1'b0 || bus.busy !== 1'b0 || bus.cwp !== 2'd3) begin
            n_fail++; $display("FAIL ovf_ack: ovf %b busy %b cwp %0d expected 0 0 3", bus.trap_ovf, bus.busy, bus.cwp);
        end
    endtask

    task automatic test_underflow;
        issue(3'd6, 32'h0);
        issue(3'd5, 32'h3);
        issue(3'd6, 32'h1);
        issue(3'd2, 32'h0);
        n_checks++;
        if (bus.trap_unf !== 1'b1 || bus.trap_ovf !== 1'b0 || bus.cwp !== 2'd3) begin
            n_fail++; $display("FAIL unf_raise: unf %b ovf %b cwp %0d expected 1 0 3", bus.trap_unf, bus.trap_ovf, bus.cwp);
        end
        bus.trap_ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.trap_ack = 1'b0;
        n_checks++;
        if (bus.trap_unf !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL unf_ack: unf %b busy %b expected 0 0", bus.trap_unf, bus.busy); end
        issue(3'd6, 32'h0);
        issue(3'd2, 32'h0);
        n_checks++;
        if (bus.cwp !== 2'd0 || bus.current_window !== 4'b0001 || bus.trap_unf !== 1'b0) begin
            n_fail++; $display("FAIL restore_wrap: cwp %0d cw %b unf %b expected 0 0001 0", bus.cwp, bus.current_window, bus.trap_unf);
        end
    endtask

    task automatic test_trap_enter_rett;
        issue(3'd6, 32'hF);
        issue(3'd3, 32'h0);
        n_checks++;
        if (bus.cwp !== 2'd3 || bus.current_window !== 4'b1000 || bus.trap_ovf !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL trap_enter: cwp %0d cw %b ovf %b busy %b expected 3 1000 0 0", bus.cwp, bus.current_window, bus.trap_ovf, bus.busy);
        end
        issue(3'd4, 32'h0);
        n_checks++;
        if (bus.trap_unf !== 1'b1 || bus.cwp !== 2'd3) begin n_fail++; $display("FAIL rett_unf: unf %b cwp %0d expected 1 3", bus.trap_unf, bus.cwp); end
    endtask

    task automatic test_busy_then_clr;
        int dones;
        dones = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'd5; bus.data_in = 32'h1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        bus.req = 1'b0;
        n_checks++;
        if (dones !== 0 || bus.cwp !== 2'd3 || bus.busy !== 1'b1 || bus.trap_unf !== 1'b1) begin
            n_fail++; $display("FAIL req_in_trap: dones %0d cwp %0d busy %b unf %b expected 0 3 1 1", dones, bus.cwp, bus.busy, bus.trap_unf);
        end
        Clr = 1'b1;
        @(negedge clk);
        Clr = 1'b0;
        n_checks++;
        if (bus.cwp !== 2'd0 || bus.wim !== 4'h0 || bus.current_window !== 4'b0001 ||
            {bus.done, bus.illegal, bus.busy, bus.trap_ovf, bus.trap_unf} !== 5'b0) begin
            n_fail++; $display("FAIL clr_in_trap: cwp %0d wim %h cw %b flags %b expected 0 0 0001 00000", bus.cwp, bus.wim,
                               bus.current_window, {bus.done, bus.illegal, bus.busy, bus.trap_ovf, bus.trap_unf});
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        dones = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'd1; bus.data_in = '0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dones !== 2 || bus.cwp !== 2'd2 || bus.current_window !== 4'b0100) begin
            n_fail++; $display("FAIL back_to_back: dones %0d cwp %0d cw %b expected 2 2 0100", dones, bus.cwp, bus.current_window);
        end
    endtask

    task automatic test_nop_reserved;
        issue(3'd0, 32'h0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.illegal !== 1'b0 || bus.cwp !== 2'd2) begin
            n_fail++; $display("FAIL nop: done %b illegal %b cwp %0d expected 1 0 2", bus.done, bus.illegal, bus.cwp);
        end
        issue(3'd7, 32'h0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.illegal !== 1'b1 || bus.cwp !== 2'd2 || bus.wim !== 4'h0) begin
            n_fail++; $display("FAIL reserved: done %b illegal %b cwp %0d wim %h expected 1 1 2 0", bus.done, bus.illegal, bus.cwp, bus.wim);
        end
    endtask

    task automatic test_nw3;
        logic [1:0] exp_chain [3];
        exp_chain[0] = 2'd2; exp_chain[1] = 2'd1; exp_chain[2] = 2'd0;
        issue3(3'd5, 32'h3);
        n_checks++;
        if (bus3.done !== 1'b1 || bus3.illegal !== 1'b1 || bus3.cwp !== 2'd0) begin
            n_fail++; $display("FAIL nw3_wrcwp_bad: done %b illegal %b cwp %0d expected 1 1 0", bus3.done, bus3.illegal, bus3.cwp);
        end
        for (int i = 0; i < 3; i++) begin
            issue3(3'd1, 32'h0);
            n_checks++;
            if (bus3.cwp !== exp_chain[i] || bus3.current_window !== (3'b001 << exp_chain[i])) begin
                n_fail++; $display("FAIL nw3_save_%0d: cwp %0d cw %b expected %0d", i, bus3.cwp, bus3.current_window, exp_chain[i]);
            end
        end
        issue3(3'd5, 32'h2);
        issue3(3'd2, 32'h0);
        n_checks++;
        if (bus3.cwp !== 2'd0 || bus3.current_window !== 3'b001) begin
            n_fail++; $display("FAIL nw3_restore_wrap: cwp %0d cw %b expected 0 001", bus3.cwp, bus3.current_window);
        end
    endtask

`ifdef WINCTL_TRAPCNT_EN
    task automatic test_trapcnt;
        n_checks++;
        if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d expected 0", ovf_count); end
        issue(3'd5, 32'h0);
        issue(3'd6, 32'h8);
        repeat (3) begin
            issue(3'd1, 32'h0);
            bus.trap_ack = 1'b1;
            repeat (2) @(negedge clk);
            bus.trap_ack = 1'b0;
        end
        n_checks++;
        if (ovf_count !== 16'd3 || unf_count !== 16'd0) begin
            n_fail++; $display("FAIL cnt_ovf: ovf %0d unf %0d expected 3 0", ovf_count, unf_count);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Clr = 1'b1;
        bus.req = 1'b0; bus.op = '0; bus.data_in = '0; bus.trap_ack = 1'b0;
        bus3.req = 1'b0; bus3.op = '0; bus3.data_in = '0; bus3.trap_ack = 1'b0;
        test_reset();
        test_save();
        test_overflow();
        test_underflow();
        test_trap_enter_rett();
        test_busy_then_clr();
        test_back_to_back();
        test_nop_reserved();
        test_nw3();
`ifdef WINCTL_TRAPCNT_EN
        Clr = 1'b1;
        @(negedge clk);
        Clr = 1'b0;
        test_trapcnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
